// File: rtl/mealy_seq_gen.sv
// ----------------------------------------------------------------------------
// mealy_seq_gen
//   Serial pattern generator. A start request in IDLE captures a PAT_W-bit
//   pattern and sends it MSB first on dout, one bit per clock, with dvalid
//   high for every pattern bit. A single DONE cycle, which pulses done,
//   closes the frame. After DONE the block returns to IDLE. All outputs come
//   straight from flops, so no input has a combinational path to an output.
//
//   Build option (macro SEQ_GEN_REPEAT_EN):
//     defined   - the rep input sets how many extra back-to-back copies of
//                 the pattern are sent. There is no gap between copies.
//     undefined - rep is ignored. Every frame is exactly PAT_W bits, and no
//                 repeat counter or pattern copy is built.
//
// Parameters
//   PAT_W   pattern length in bits (2..16)
//   REP_W   width of the repeat-count input
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   start    frame request, sampled only in IDLE
//   pattern  bits to send, MSB first
//   rep      extra repetitions (repeat build only)
//   dout     serial data, 0 whenever dvalid is low
//   dvalid   dout carries a pattern bit
//   busy     frame accepted and not yet finished (covers DONE)
//   done     one-cycle pulse after the last bit of a frame
// ----------------------------------------------------------------------------
module mealy_seq_gen #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] rep,
    output logic             dout,
    output logic             dvalid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t             state_r, state_s;
    // shift_r holds the bits still to be sent; its MSB is the next bit.
    logic [PAT_W-1:0]   shift_r, shift_s;
    // bitcnt_r counts the bits remaining after the one currently on dout.
    logic [CNT_W-1:0]   bitcnt_r, bitcnt_s;
    logic               dout_s, dvalid_s, busy_s, done_s;

`ifdef SEQ_GEN_REPEAT_EN
    logic [REP_W-1:0]   repcnt_r, repcnt_s;
    logic [PAT_W-1:0]   pat_r, pat_s;
`else
    logic               unused_rep_s;
    assign unused_rep_s = ^rep;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and next values for the datapath and output registers.
    // Output values are computed one cycle early so they can be registered.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        bitcnt_s = bitcnt_r;
        dout_s   = 1'b0;
        dvalid_s = 1'b0;
        busy_s   = 1'b0;
        done_s   = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
        repcnt_s = repcnt_r;
        pat_s    = pat_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    // The first bit goes out in the cycle right after acceptance.
                    state_s  = ST_SEND;
                    dout_s   = pattern[PAT_W-1];
                    dvalid_s = 1'b1;
                    busy_s   = 1'b1;
                    shift_s  = {pattern[PAT_W-2:0], 1'b0};
                    bitcnt_s = CNT_W'(PAT_W - 1);
`ifdef SEQ_GEN_REPEAT_EN
                    repcnt_s = rep;
                    pat_s    = pattern;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                busy_s = 1'b1;
                if (bitcnt_r != {CNT_W{1'b0}}) begin
                    dout_s   = shift_r[PAT_W-1];
                    dvalid_s = 1'b1;
                    shift_s  = {shift_r[PAT_W-2:0], 1'b0};
                    bitcnt_s = bitcnt_r - CNT_W'(1);
                end else begin
`ifdef SEQ_GEN_REPEAT_EN
                    if (repcnt_r != {REP_W{1'b0}}) begin
                        // Reload from the captured copy so there is no gap between repeats.
                        dout_s   = pat_r[PAT_W-1];
                        dvalid_s = 1'b1;
                        shift_s  = {pat_r[PAT_W-2:0], 1'b0};
                        bitcnt_s = CNT_W'(PAT_W - 1);
                        repcnt_s = repcnt_r - REP_W'(1);
                    end else begin
                        state_s  = ST_DONE;
                        done_s   = 1'b1;
                        shift_s  = {PAT_W{1'b0}};
                    end
`else
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                    shift_s = {PAT_W{1'b0}};
`endif
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r  <= {PAT_W{1'b0}};
            bitcnt_r <= {CNT_W{1'b0}};
            dout     <= 1'b0;
            dvalid   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
            repcnt_r <= {REP_W{1'b0}};
            pat_r    <= {PAT_W{1'b0}};
`endif
        end else begin
            shift_r  <= shift_s;
            bitcnt_r <= bitcnt_s;
            dout     <= dout_s;
            dvalid   <= dvalid_s;
            busy     <= busy_s;
            done     <= done_s;
`ifdef SEQ_GEN_REPEAT_EN
            repcnt_r <= repcnt_s;
            pat_r    <= pat_s;
`endif
        end
    end

endmodule

// File: tb/tb_mealy_seq_gen.sv
module tb_mealy_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] rep;
    logic       dout, dvalid, busy, done;

    int n_tests = 0;
    int n_fail  = 0;

    mealy_seq_gen #(.PAT_W(4), .REP_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .rep     (rep),
        .dout    (dout),
        .dvalid  (dvalid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if ({dout, dvalid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: dout/dvalid/busy/done=%b expected 0000",
                     {dout, dvalid, busy, done});
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({dout, dvalid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_after_reset: outputs=%b expected 0000", {dout, dvalid, busy, done});
        end
    endtask

    task automatic test_basic;
        logic [3:0] pat;
        pat = 4'b1010;
        pattern = pat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dvalid !== 1'b1 || dout !== pat[3-i] || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_bit%0d: dvalid=%b dout=%b busy=%b done=%b expected 1 %b 1 0",
                         i, dvalid, dout, busy, done, pat[3-i]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || dvalid !== 1'b0 || dout !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: done=%b dvalid=%b dout=%b busy=%b expected 1 0 0 1",
                     done, dvalid, dout, busy);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: busy=%b done=%b dvalid=%b expected 0 0 0", busy, done, dvalid);
        end
    endtask

    task automatic test_repeat;
`ifdef SEQ_GEN_REPEAT_EN
        logic [11:0] exp_bits;
        exp_bits = 12'b1011_1011_1011;
        pattern  = 4'b1011;
        rep      = 4'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rep   = 4'd0;
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (dvalid !== 1'b1 || dout !== exp_bits[11-i] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL repeat_bit%0d: dvalid=%b dout=%b done=%b expected 1 %b 0",
                         i, dvalid, dout, done, exp_bits[11-i]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_done: done=%b dvalid=%b expected 1 0", done, dvalid);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_idle: busy=%b done=%b expected 0 0", busy, done);
        end
`else
        logic [3:0] pat;
        pat     = 4'b1100;
        pattern = pat;
        rep     = 4'd3;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dvalid !== 1'b1 || dout !== pat[3-i] || done !== 1'b0) begin
                n_fail++;
                $display("FAIL norep_bit%0d: dvalid=%b dout=%b done=%b expected 1 %b 0",
                         i, dvalid, dout, done, pat[3-i]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || dvalid !== 1'b0 || dout !== 1'b0) begin
            n_fail++;
            $display("FAIL norep_done: done=%b dvalid=%b dout=%b expected 1 0 0", done, dvalid, dout);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL norep_idle: busy=%b dvalid=%b expected 0 0", busy, dvalid);
        end
        rep = 4'd0;
`endif
    endtask

    task automatic test_reset_mid;
        logic [3:0] pat;
        pat     = 4'b0110;
        pattern = pat;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (dvalid !== 1'b1 || dout !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_bit0: dvalid=%b dout=%b expected 1 0", dvalid, dout);
        end
        @(negedge clk);
        n_tests++;
        if (dvalid !== 1'b1 || dout !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_bit1: dvalid=%b dout=%b expected 1 1", dvalid, dout);
        end
        // Assert reset between edges and look before the next rising edge.
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({dout, dvalid, busy, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstmid_async: outputs=%b expected 0000", {dout, dvalid, busy, done});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_held%0d: done=%b busy=%b expected 0 0", i, done, busy);
            end
        end
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dvalid !== 1'b1 || dout !== pat[3-i]) begin
                n_fail++;
                $display("FAIL rstmid_resend%0d: dvalid=%b dout=%b expected 1 %b",
                         i, dvalid, dout, pat[3-i]);
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_done: done=%b expected 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_start_ignored;
        logic [3:0] pat;
        pat     = 4'b1010;
        pattern = pat;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dvalid !== 1'b1 || dout !== pat[3-i]) begin
                n_fail++;
                $display("FAIL ignore_bit%0d: dvalid=%b dout=%b expected 1 %b",
                         i, dvalid, dout, pat[3-i]);
            end
            if (i == 1) begin
                start   = 1'b1;
                pattern = 4'b0001;
                rep     = 4'd15;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (done !== 1'b1 || dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_done: done=%b dvalid=%b expected 1 0", done, dvalid);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || dvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_idle: busy=%b dvalid=%b expected 0 0", busy, dvalid);
        end
        rep = 4'd0;
    endtask

    task automatic test_back_to_back;
        logic [3:0] pat;
        logic       exp_v, exp_d, exp_done;
        int         p;
        bit         idle_seen;
        pat     = 4'b1001;
        pattern = pat;
        start   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            p        = (c - 1) % 6;
            exp_v    = (p < 4);
            exp_d    = exp_v ? pat[3-p] : 1'b0;
            exp_done = (p == 4);
            n_tests++;
            if (dvalid !== exp_v || dout !== exp_d || done !== exp_done) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: dvalid=%b dout=%b done=%b expected %b %b %b",
                         c, dvalid, dout, done, exp_v, exp_d, exp_done);
            end
        end
        start = 1'b0;
        idle_seen = 1'b0;
        for (int i = 0; i < 20 && !idle_seen; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && done === 1'b0) idle_seen = 1'b1;
        end
        n_tests++;
        if (!idle_seen) begin
            n_fail++;
            $display("FAIL b2b_drain: busy=%b expected 0 within 20 cycles", busy);
        end
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        pattern = 4'b0000;
        rep     = 4'd0;
        test_reset();
        test_basic();
        test_repeat();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mealy_seq_gen.md
MEALY_SEQ_GEN -- requirements
Module: mealy_seq_gen

Interface
REQ-001 Parameter: PAT_W, default 4, pattern length in bits (legal range 2..16).
REQ-002 Parameter: REP_W, default 4, width of repeat-count input.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  request to transmit one frame; sampled only in IDLE.
REQ-006 Port: pattern  input  PAT_W  bit pattern to transmit, MSB sent first.
REQ-007 Port: rep  input  REP_W  extra back-to-back repetitions of pattern (used only when repeat feature compiled in).
REQ-008 Port: dout  output  1  serial data bit, same format as detector input x.
REQ-009 Port: dvalid  output  1  high when dout carries a pattern bit.
REQ-010 Port: busy  output  1  high from frame acceptance through DONE state.
REQ-011 Port: done  output  1  one-cycle pulse after last bit of frame.

Function
REQ-012 FSM SHALL have exactly three states: IDLE, SEND, DONE; encoding implementation's choice.
REQ-013 IDLE: start=1 at clk edge SHALL capture pattern into shift register, capture rep into repeat counter, load bit counter to PAT_W-1, go to SEND; start=0 stays IDLE.
REQ-014 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-015 First bit SHALL appear on dout with dvalid=1 in the first cycle after start is sampled (latency 1 cycle).
REQ-016 SEND: each cycle dout=current MSB of shift register, dvalid=1; shift left by one, decrement bit counter.
REQ-017 Bit counter reaching 0 with repeat counter 0 SHALL transition to DONE; dvalid=0 in DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, busy=1, then return to IDLE unconditionally.
REQ-019 start while not in IDLE SHALL be ignored; pattern/rep changes while busy SHALL NOT affect frame in progress.
REQ-020 start held high continuously SHALL yield back-to-back frames separated by DONE cycle plus one IDLE cycle (2 cycles dvalid=0).
REQ-021 dout SHALL be 0 whenever dvalid=0.
REQ-022 Pattern all-zeros or all-ones SHALL be transmitted normally (PAT_W valid bits); no special casing.

Reset
REQ-023 rst=0 SHALL immediately, without a clock edge, force state IDLE and dout=0, dvalid=0, busy=0, done=0, clearing all counters and shift register.
REQ-024 Reset asserted mid-frame SHALL abort the frame; no done pulse SHALL be produced for the aborted frame.
REQ-025 After rst returns high, first start SHALL be accepted on the next rising edge.

Configuration
REQ-026 Macro SEQ_GEN_REPEAT_EN defined: when bit counter reaches 0 and repeat counter >0, shift register SHALL reload captured pattern, repeat counter decrements, SEND continues with no gap; total dvalid cycles = PAT_W*(rep+1).
REQ-027 Macro SEQ_GEN_REPEAT_EN undefined: rep port present but ignored; every frame is exactly PAT_W bits; repeat counter not synthesized.

Verification
REQ-028 PAT_W=4, pattern=4'b1010, one-cycle start pulse -> cycles 1-4 dout=1,0,1,0 with dvalid=1; cycle 5 done=1; cycle 6 busy=0.
REQ-029 SEQ_GEN_REPEAT_EN defined, pattern=4'b1011, rep=2 -> 12 contiguous valid bits 101110111011, single done pulse after bit 12.
REQ-030 SEQ_GEN_REPEAT_EN undefined, rep=3, pattern=4'b1100 -> exactly 4 valid bits 1100, done after bit 4.
REQ-031 pattern=4'b0110, rst driven low between edges during bit 2 -> all outputs 0 immediately; no done; new start after release sends full 0110.
REQ-032 start pulsed again during SEND with pattern changed to 4'b0001 -> ignored; original bits continue unchanged.
REQ-033 start held high for 20 cycles, pattern=4'b1001 -> frames 1001 repeat with exactly 2 dvalid=0 cycles between frames.
